// File: rtl/uart_monitor_frame_sampler.sv
// Oversampling UART receive sequencer: start/data/parity/stop FSM with per-frame latched format.
// Optional macro UART_MON_MAJORITY_VOTE_EN selects 3-sample majority voting per bit.
module uart_monitor_frame_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int MAX_DATA   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           data_len,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop_two,
  input  logic                 serial_in,
  output logic                 frame_valid,
  output logic [MAX_DATA-1:0]  frame_data,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BW   = (MAX_DATA > 1) ? $clog2(MAX_DATA) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [OS_W-1:0] T_LAST = OS_W'(OVERSAMPLE - 1);
`ifdef UART_MON_MAJORITY_VOTE_EN
  localparam logic [OS_W-1:0] T_V0  = OS_W'(OVERSAMPLE / 2 - 2);
  localparam logic [OS_W-1:0] T_V1  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] T_SMP = OS_W'(OVERSAMPLE / 2);
`else
  localparam logic [OS_W-1:0] T_SMP = OS_W'(OVERSAMPLE / 2 - 1);
`endif

  logic [2:0]           r_state;
  logic                 r_sync1, r_sync2, r_prev;
  logic [DIV_WIDTH-1:0] r_div;
  logic [OS_W-1:0]      r_os;
  logic [BW-1:0]        r_bit;
  logic [MAX_DATA-1:0]  r_data;
  logic                 r_pe, r_fe;
  logic [1:0]           r_len;
  logic                 r_pen, r_podd, r_stop2;

  logic                 w_start, w_tick, w_smp, w_end, w_bit, w_fe;
  logic [BW-1:0]        w_last_bit;

  assign busy       = (r_state != S_IDLE);
  assign w_start    = (r_state == S_IDLE) && enable && r_prev && !r_sync2;
  assign w_tick     = busy && (r_div == '0);
  assign w_smp      = w_tick && (r_os == T_SMP);
  assign w_end      = w_tick && (r_os == T_LAST);
  assign w_last_bit = BW'(r_len) + BW'(4);
  assign w_fe       = r_fe | ~w_bit;

`ifdef UART_MON_MAJORITY_VOTE_EN
  logic r_v0, r_v1;
  assign w_bit = (r_v0 & r_v1) | (r_v0 & r_sync2) | (r_v1 & r_sync2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v0 <= 1'b1;
      r_v1 <= 1'b1;
    end else if (w_tick) begin
      if (r_os == T_V0) r_v0 <= r_sync2;
      if (r_os == T_V1) r_v1 <= r_sync2;
    end
  end
`else
  assign w_bit = r_sync2;
`endif

  // Tick divider and in-bit tick index; both restart on the start edge to align the sample phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_os  <= '0;
    end else if (w_start) begin
      r_div <= baud_div;
      r_os  <= '0;
    end else if (busy) begin
      if (w_tick) begin
        r_div <= baud_div;
        r_os  <= (r_os == T_LAST) ? '0 : r_os + OS_W'(1);
      end else begin
        r_div <= r_div - DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_prev      <= 1'b1;
      r_bit       <= '0;
      r_data      <= '0;
      r_pe        <= 1'b0;
      r_fe        <= 1'b0;
      r_len       <= 2'd0;
      r_pen       <= 1'b0;
      r_podd      <= 1'b0;
      r_stop2     <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      r_sync1     <= serial_in;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      frame_valid <= 1'b0;
      if (busy && !enable) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (w_start) begin
            r_state <= S_START;
            r_bit   <= '0;
            r_data  <= '0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_len   <= data_len;
            r_pen   <= parity_en;
            r_podd  <= parity_odd;
            r_stop2 <= stop_two;
          end
          S_START: begin
            if (w_smp && w_bit) r_state <= S_IDLE;
            else if (w_end)     r_state <= S_DATA;
          end
          S_DATA: begin
            if (w_smp) r_data[r_bit] <= w_bit;
            if (w_end) begin
              if (r_bit == w_last_bit) begin
                r_bit   <= '0;
                r_state <= r_pen ? S_PARITY : S_STOP;
              end else begin
                r_bit <= r_bit + BW'(1);
              end
            end
          end
          S_PARITY: begin
            if (w_smp) r_pe <= (^r_data) ^ w_bit ^ r_podd;
            if (w_end) r_state <= S_STOP;
          end
          S_STOP: begin
            // Finish at the mid-bit sample of the last stop bit so a following start edge is not missed.
            if (w_smp) begin
              r_fe <= w_fe;
              if (!r_stop2 || r_bit[0]) begin
                r_state     <= S_DONE;
                frame_valid <= 1'b1;
                frame_data  <= r_data;
                parity_err  <= r_pe;
                framing_err <= w_fe;
                break_det   <= w_fe && (r_data == '0);
              end
            end else if (w_end) begin
              r_bit <= BW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_monitor_frame_sampler.sv
// Directed table-driven bench for uart_monitor_frame_sampler plus multi-cycle corner sequences.
module tb_uart_monitor_frame_sampler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] baud_div;
  logic [1:0]  data_len;
  logic        parity_en, parity_odd, stop_two, serial_in;
  logic        frame_valid;
  logic [7:0]  frame_data;
  logic        parity_err, framing_err, break_det, busy;

  uart_monitor_frame_sampler dut (
    .clk(clk), .reset(reset), .enable(enable), .baud_div(baud_div),
    .data_len(data_len), .parity_en(parity_en), .parity_odd(parity_odd),
    .stop_two(stop_two), .serial_in(serial_in), .frame_valid(frame_valid),
    .frame_data(frame_data), .parity_err(parity_err), .framing_err(framing_err),
    .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe, fe, bd;
  } rec_t;

  typedef struct {
    int         baud;
    logic [1:0] len;
    logic       pen, podd, s2, pbit, stop1, stop2;
    logic [7:0] d;
    logic [7:0] ed;
    logic       epe, efe, ebd;
  } vec_t;

  rec_t fv_q[$];
  int   fv_cyc[$];
  int   cyc = 0;
  int   start_cyc;
  int   n_checks = 0;
  int   n_pass = 0;
  vec_t vecs[11];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_q.push_back({frame_data, parity_err, framing_err, break_det});
      fv_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d, input logic pe,
                              input logic fe, input logic bd);
    rec_t r;
    r = 'x;
    chk({name, ".count"}, fv_q.size(), 1);
    if (fv_q.size() > 0) r = fv_q[0];
    chk({name, ".data"}, {24'd0, r.d}, {24'd0, d});
    chk({name, ".parity_err"}, {31'd0, r.pe}, {31'd0, pe});
    chk({name, ".framing_err"}, {31'd0, r.fe}, {31'd0, fe});
    chk({name, ".break_det"}, {31'd0, r.bd}, {31'd0, bd});
  endtask

  task automatic clear_frames();
    fv_q.delete();
    fv_cyc.delete();
  endtask

  // Format inputs are scrambled once the start bit is on the line; the sampler must ignore them.
  task automatic send_frame(input vec_t v);
    int bc;
    bc = 16 * (v.baud + 1);
    baud_div   = 16'(v.baud);
    data_len   = v.len;
    parity_en  = v.pen;
    parity_odd = v.podd;
    stop_two   = v.s2;
    serial_in  = 1'b0;
    start_cyc  = cyc;
    wait_clks(bc);
    data_len   = v.len ^ 2'b11;
    parity_en  = ~v.pen;
    parity_odd = ~v.podd;
    stop_two   = ~v.s2;
    for (int i = 0; i < int'(v.len) + 5; i++) begin
      serial_in = v.d[i];
      wait_clks(bc);
    end
    if (v.pen) begin
      serial_in = v.pbit;
      wait_clks(bc);
    end
    serial_in = v.stop1;
    wait_clks(bc);
    if (v.s2) begin
      serial_in = v.stop2;
      wait_clks(bc);
    end
    serial_in  = 1'b1;
    data_len   = v.len;
    parity_en  = v.pen;
    parity_odd = v.podd;
    stop_two   = v.s2;
  endtask

  initial begin
    int   lat;
    int   exp_lat;
    vec_t v;

    //          baud len pen podd s2 pbit st1 st2  d      ed    epe efe ebd
    vecs[0]  = '{3, 2'd3, 0, 0, 0, 0, 1, 1, 8'hA5, 8'hA5, 0, 0, 0};
    vecs[1]  = '{3, 2'd2, 1, 0, 0, 0, 1, 1, 8'h35, 8'h35, 0, 0, 0};
    vecs[2]  = '{3, 2'd2, 1, 0, 0, 1, 1, 1, 8'h35, 8'h35, 1, 0, 0};
    vecs[3]  = '{3, 2'd3, 0, 0, 1, 0, 1, 0, 8'h3C, 8'h3C, 0, 1, 0};
    vecs[4]  = '{3, 2'd0, 1, 1, 0, 0, 1, 1, 8'h13, 8'h13, 0, 0, 0};
    vecs[5]  = '{3, 2'd1, 1, 0, 0, 1, 1, 1, 8'h3F, 8'h3F, 1, 0, 0};
    vecs[6]  = '{3, 2'd1, 1, 1, 1, 0, 1, 1, 8'h2A, 8'h2A, 0, 0, 0};
    vecs[7]  = '{3, 2'd3, 0, 0, 1, 0, 0, 1, 8'h81, 8'h81, 0, 1, 0};
    vecs[8]  = '{0, 2'd3, 0, 0, 0, 0, 1, 1, 8'h96, 8'h96, 0, 0, 0};
    vecs[9]  = '{1, 2'd3, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0};
    vecs[10] = '{2, 2'd3, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 1};

`ifdef UART_MON_MAJORITY_VOTE_EN
    exp_lat = 614;
`else
    exp_lat = 610;
`endif

    reset = 1'b1; enable = 1'b1; baud_div = 16'd3; data_len = 2'd3;
    parity_en = 1'b0; parity_odd = 1'b0; stop_two = 1'b0; serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.frame_valid", {31'd0, frame_valid}, 0);
    chk("reset.frame_data", {24'd0, frame_data}, 0);
    chk("reset.flags", {29'd0, parity_err, framing_err, break_det}, 0);
    chk("reset.busy", {31'd0, busy}, 0);
    reset = 1'b0;
    wait_clks(4);

    for (int i = 0; i < 11; i++) begin
      clear_frames();
      send_frame(vecs[i]);
      wait_clks(2 * 16 * (vecs[i].baud + 1));
      expect_frame($sformatf("vec%0d", i), vecs[i].ed, vecs[i].epe, vecs[i].efe, vecs[i].ebd);
      if (i == 0 && fv_cyc.size() > 0) begin
        lat = fv_cyc[0] - start_cyc;
        n_checks++;
        if (lat >= exp_lat - 4 && lat <= exp_lat + 4) n_pass++;
        else $display("FAIL latency: got %0d expected %0d +/-4", lat, exp_lat);
      end
    end

    // Line held low for 20 bit times: one break frame, then nothing until it rises and falls again.
    clear_frames();
    baud_div = 16'd3; data_len = 2'd3; parity_en = 1'b0; stop_two = 1'b0;
    serial_in = 1'b0;
    wait_clks(20 * 64);
    expect_frame("break", 8'h00, 1'b0, 1'b1, 1'b1);
    chk("break.busy_low_line", {31'd0, busy}, 0);
    serial_in = 1'b1;
    wait_clks(2 * 64);
    chk("break.no_extra", fv_q.size(), 1);
    clear_frames();
    v = vecs[0]; v.d = 8'h5A;
    send_frame(v);
    wait_clks(2 * 64);
    expect_frame("after_break", 8'h5A, 1'b0, 1'b0, 1'b0);

    // Glitch of 3 ticks: false start, back to idle, no frame.
    clear_frames();
    serial_in = 1'b0;
    wait_clks(6);
    chk("glitch.busy", {31'd0, busy}, 1);
    wait_clks(6);
    serial_in = 1'b1;
    wait_clks(2 * 64);
    chk("glitch.idle", {31'd0, busy}, 0);
    chk("glitch.no_frame", fv_q.size(), 0);

    // Back-to-back frames with no idle gap, then reset in the middle of a third.
    clear_frames();
    v = vecs[0]; v.d = 8'h01;
    send_frame(v);
    v.d = 8'hFF;
    send_frame(v);
    wait_clks(64);
    chk("b2b.count", fv_q.size(), 2);
    if (fv_q.size() == 2) begin
      chk("b2b.first", {24'd0, fv_q[0].d}, 32'h01);
      chk("b2b.second", {24'd0, fv_q[1].d}, 32'hFF);
      chk("b2b.flags", {26'd0, fv_q[0].pe, fv_q[0].fe, fv_q[0].bd,
                        fv_q[1].pe, fv_q[1].fe, fv_q[1].bd}, 0);
    end
    clear_frames();
    serial_in = 1'b0;
    wait_clks(64);
    serial_in = 1'b1;
    wait_clks(64);
    chk("midframe.busy", {31'd0, busy}, 1);
    reset = 1'b1;
    #1;
    chk("midreset.busy", {31'd0, busy}, 0);
    chk("midreset.frame_data", {24'd0, frame_data}, 0);
    chk("midreset.frame_valid", {31'd0, frame_valid}, 0);
    wait_clks(2);
    reset = 1'b0;
    wait_clks(10 * 64);
    chk("midreset.no_frame", fv_q.size(), 0);
    v = vecs[0]; v.d = 8'hC3;
    send_frame(v);
    wait_clks(2 * 64);
    expect_frame("after_reset", 8'hC3, 1'b0, 1'b0, 1'b0);

    // Enable dropped mid-frame: abort without a frame, captured outputs held.
    clear_frames();
    serial_in = 1'b0;
    wait_clks(2 * 64);
    serial_in = 1'b1;
    wait_clks(64);
    chk("abort.busy_before", {31'd0, busy}, 1);
    enable = 1'b0;
    wait_clks(2);
    chk("abort.busy_after", {31'd0, busy}, 0);
    chk("abort.frame_data_held", {24'd0, frame_data}, 32'hC3);
    wait_clks(10 * 64);
    chk("abort.no_frame", fv_q.size(), 0);
    enable = 1'b1;
    wait_clks(4);
    v = vecs[0]; v.d = 8'h7E;
    send_frame(v);
    wait_clks(2 * 64);
    expect_frame("after_abort", 8'h7E, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
